// File: rtl/uart_transceiver_param_if.sv
// Host-side bundle of the UART transceiver: TX FIFO write port and RX word port.
// The master drives requests, the slave (transceiver) returns status and data.
interface uart_transceiver_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 Tx_EN;
    logic                 Tx_WR;
    logic [DATA_BITS-1:0] Tx_DATA;
    logic                 Tx_BUSY;
    logic                 Tx_IDLE;
    logic                 Rx_EN;
    logic                 Rx_RD;
    logic [DATA_BITS-1:0] Rx_DATA;
    logic                 Rx_VALID;
    logic                 Rx_FERROR;
    logic                 Rx_PERROR;
    logic                 Rx_OVERRUN;

    modport master (
        output Tx_EN, Tx_WR, Tx_DATA, Rx_EN, Rx_RD,
        input  Tx_BUSY, Tx_IDLE, Rx_DATA, Rx_VALID,
        input  Rx_FERROR, Rx_PERROR, Rx_OVERRUN
    );

    modport slave (
        input  Tx_EN, Tx_WR, Tx_DATA, Rx_EN, Rx_RD,
        output Tx_BUSY, Tx_IDLE, Rx_DATA, Rx_VALID,
        output Rx_FERROR, Rx_PERROR, Rx_OVERRUN
    );
endinterface

// File: rtl/uart_transceiver_param.sv
// Parametrised UART: FIFO-buffered TX, 16x oversampled RX, runtime baud/parity.
// Each direction latches its divisor and parity mode at frame start.
module uart_transceiver_param #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic [1:0] parity_mode,
    input  logic       loopback,
    output logic       Tx_D,
    input  logic       Rx_D,
    uart_transceiver_param_if.slave host
);
    localparam int AW = $clog2(FIFO_DEPTH);

    function automatic logic [31:0] div_of(input logic [2:0] sel);
        int baud;
        int d;
        case (sel)
            3'd0:    baud = 300;
            3'd1:    baud = 1200;
            3'd2:    baud = 4800;
            3'd3:    baud = 9600;
            3'd4:    baud = 19200;
            3'd5:    baud = 38400;
            3'd6:    baud = 57600;
            default: baud = 115200;
        endcase
        d = CLK_FREQ / (16 * baud);
        return (d < 1) ? 32'd1 : 32'(d);
    endfunction

    typedef enum logic [2:0] {
        T_IDLE, T_START, T_DATA, T_PAR, T_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        R_IDLE, R_START, R_DATA, R_PAR, R_STOP
    } rx_state_t;

    // ---------------- TX FIFO ----------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr, rd_ptr;
    logic                 empty, full, push, pop;
    logic [DATA_BITS-1:0] head;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];
    assign push  = host.Tx_WR && (!full || pop);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= host.Tx_DATA;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // ---------------- TX FSM ----------------
    tx_state_t            tx_state;
    logic                 tx_line;
    logic [31:0]          tx_div, tx_divcnt;
    logic [3:0]           tx_tcnt, tx_bcnt;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par_en, tx_par_bit;
    logic                 tx_tick, tx_bit_end, tx_can_start;

    assign tx_tick    = (tx_divcnt == tx_div - 32'd1);
    assign tx_bit_end = (tx_state != T_IDLE) && tx_tick && (tx_tcnt == 4'd15);
    // A new frame may start from IDLE or straight out of the last stop bit
    assign tx_can_start = (tx_state == T_IDLE) ||
        (tx_state == T_STOP && tx_bit_end && tx_bcnt == 4'(STOP_BITS - 1));
    assign pop = tx_can_start && !empty && host.Tx_EN;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state   <= T_IDLE;
            tx_line    <= 1'b1;
            tx_div     <= 32'd1;
            tx_divcnt  <= '0;
            tx_tcnt    <= '0;
            tx_bcnt    <= '0;
            tx_shift   <= '0;
            tx_par_en  <= 1'b0;
            tx_par_bit <= 1'b0;
        end else begin
            if (tx_state != T_IDLE) begin
                if (tx_tick) begin
                    tx_divcnt <= '0;
                    tx_tcnt   <= tx_tcnt + 4'd1;
                end else begin
                    tx_divcnt <= tx_divcnt + 32'd1;
                end
            end
            if (pop) begin
                tx_state   <= T_START;
                tx_line    <= 1'b0;
                tx_shift   <= head;
                tx_par_en  <= parity_mode[0] ^ parity_mode[1];
                tx_par_bit <= (parity_mode == 2'b10) ? ~^head : ^head;
                tx_div     <= div_of(baud_select);
                tx_divcnt  <= '0;
                tx_tcnt    <= '0;
                tx_bcnt    <= '0;
            end else if (tx_bit_end) begin
                case (tx_state)
                    T_START: begin
                        tx_state <= T_DATA;
                        tx_line  <= tx_shift[0];
                        tx_bcnt  <= '0;
                    end
                    T_DATA: begin
                        if (tx_bcnt == 4'(DATA_BITS - 1)) begin
                            tx_bcnt <= '0;
                            if (tx_par_en) begin
                                tx_state <= T_PAR;
                                tx_line  <= tx_par_bit;
                            end else begin
                                tx_state <= T_STOP;
                                tx_line  <= 1'b1;
                            end
                        end else begin
                            tx_bcnt  <= tx_bcnt + 4'd1;
                            tx_shift <= tx_shift >> 1;
                            tx_line  <= tx_shift[1];
                        end
                    end
                    T_PAR: begin
                        tx_state <= T_STOP;
                        tx_line  <= 1'b1;
                        tx_bcnt  <= '0;
                    end
                    T_STOP: begin
                        if (tx_bcnt == 4'(STOP_BITS - 1))
                            tx_state <= T_IDLE;
                        else
                            tx_bcnt <= tx_bcnt + 4'd1;
                    end
                    default: tx_state <= T_IDLE;
                endcase
            end
        end
    end

    assign Tx_D         = loopback | tx_line;
    assign host.Tx_BUSY = full;
    assign host.Tx_IDLE = empty && (tx_state == T_IDLE);

    // ---------------- RX ----------------
    rx_state_t            rx_state;
    logic                 rx_s1, rx_s2;
    logic [31:0]          rx_div, rx_divcnt;
    logic [3:0]           rx_tcnt, rx_bcnt;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_par_en, rx_par_odd, rx_par_bit;
    logic                 rx_tick, rx_sample, rx_done;

    assign rx_tick   = (rx_divcnt == rx_div - 32'd1);
    assign rx_sample = rx_tick && (rx_tcnt == 4'd15);
    assign rx_done   = host.Rx_EN && (rx_state == R_STOP) && rx_sample;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_state   <= R_IDLE;
            rx_div     <= 32'd1;
            rx_divcnt  <= '0;
            rx_tcnt    <= '0;
            rx_bcnt    <= '0;
            rx_shift   <= '0;
            rx_par_en  <= 1'b0;
            rx_par_odd <= 1'b0;
            rx_par_bit <= 1'b0;
            host.Rx_DATA    <= '0;
            host.Rx_VALID   <= 1'b0;
            host.Rx_FERROR  <= 1'b0;
            host.Rx_PERROR  <= 1'b0;
            host.Rx_OVERRUN <= 1'b0;
        end else begin
            rx_s1 <= loopback ? tx_line : Rx_D;
            rx_s2 <= rx_s1;
            if (!host.Rx_EN) begin
                rx_state <= R_IDLE;
            end else begin
                if (rx_state != R_IDLE) begin
                    if (rx_tick) begin
                        rx_divcnt <= '0;
                        rx_tcnt   <= rx_tcnt + 4'd1;
                    end else begin
                        rx_divcnt <= rx_divcnt + 32'd1;
                    end
                end
                case (rx_state)
                    R_IDLE: if (!rx_s2) begin
                        rx_state   <= R_START;
                        rx_div     <= div_of(baud_select);
                        rx_par_en  <= parity_mode[0] ^ parity_mode[1];
                        rx_par_odd <= (parity_mode == 2'b10);
                        rx_divcnt  <= '0;
                        rx_tcnt    <= '0;
                        rx_bcnt    <= '0;
                    end
                    // Mid start bit: a line back at 1 was only a glitch
                    R_START: if (rx_tick && rx_tcnt == 4'd7) begin
                        if (rx_s2) begin
                            rx_state <= R_IDLE;
                        end else begin
                            rx_state <= R_DATA;
                            rx_tcnt  <= '0;
                        end
                    end
                    R_DATA: if (rx_sample) begin
                        rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
                        if (rx_bcnt == 4'(DATA_BITS - 1))
                            rx_state <= rx_par_en ? R_PAR : R_STOP;
                        else
                            rx_bcnt <= rx_bcnt + 4'd1;
                    end
                    R_PAR: if (rx_sample) begin
                        rx_par_bit <= rx_s2;
                        rx_state   <= R_STOP;
                    end
                    R_STOP: if (rx_sample) rx_state <= R_IDLE;
                    default: rx_state <= R_IDLE;
                endcase
            end
            if (rx_done) begin
                host.Rx_DATA    <= rx_shift;
                host.Rx_FERROR  <= !rx_s2;
                host.Rx_PERROR  <= rx_par_en &&
                    ((^rx_shift ^ rx_par_bit) != rx_par_odd);
                host.Rx_VALID   <= 1'b1;
                host.Rx_OVERRUN <= !host.Rx_RD &&
                    (host.Rx_OVERRUN || host.Rx_VALID);
            end else if (host.Rx_RD) begin
                host.Rx_VALID   <= 1'b0;
                host.Rx_OVERRUN <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_transceiver_param.sv
// Directed bench for uart_transceiver_param at DIV=1 (16 cycles per bit).
// Serial waveforms are hand-encoded as {stop, [parity], data, start} vectors.
module tb_uart_transceiver_param;
    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] baud_select;
    logic [1:0] parity_mode;
    logic       loopback;
    logic       use_tx;
    logic       rx_bb;
    logic       tx_d;
    logic       rx_d;

    int vectors = 0;
    int errors  = 0;

    uart_transceiver_param_if #(.DATA_BITS(8)) hif ();

    assign rx_d = use_tx ? tx_d : rx_bb;

    uart_transceiver_param #(
        .CLK_FREQ  (1_843_200),
        .DATA_BITS (8),
        .STOP_BITS (1),
        .FIFO_DEPTH(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .baud_select(baud_select),
        .parity_mode(parity_mode),
        .loopback   (loopback),
        .Tx_D       (tx_d),
        .Rx_D       (rx_d),
        .host       (hif)
    );

    always #5 clk = ~clk;

    task automatic write_word(input logic [7:0] d);
        hif.Tx_WR   = 1'b1;
        hif.Tx_DATA = d;
        @(negedge clk);
        hif.Tx_WR   = 1'b0;
    endtask

    task automatic rx_read();
        hif.Rx_RD = 1'b1;
        @(negedge clk);
        hif.Rx_RD = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (hif.Rx_VALID === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_tx_idle();
        for (int i = 0; i < 2000; i++) begin
            if (hif.Tx_IDLE === 1'b1) break;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask

    // Find the start bit, then sample each bit at its middle
    task automatic capture_tx(input int n, output logic [31:0] got,
                              output bit ok);
        got = '0;
        ok  = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (tx_d === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            repeat (8) @(negedge clk);
            got[0] = tx_d;
            for (int b = 1; b < n; b++) begin
                repeat (16) @(negedge clk);
                got[b] = tx_d;
            end
        end
    endtask

    task automatic send_rx(input logic [7:0] d, input logic pen,
                           input logic pbit, input logic stop);
        rx_bb = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_bb = d[i];
            repeat (16) @(negedge clk);
        end
        if (pen) begin
            rx_bb = pbit;
            repeat (16) @(negedge clk);
        end
        rx_bb = stop;
        repeat (16) @(negedge clk);
        rx_bb = 1'b1;
    endtask

    task automatic test_reset();
        logic [12:0] got;
        logic [12:0] exp;
        got = {tx_d, hif.Tx_BUSY, hif.Tx_IDLE, hif.Rx_DATA,
               hif.Rx_VALID, hif.Rx_FERROR};
        exp = {1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", got, exp);
        end
        vectors++;
        if ({hif.Rx_PERROR, hif.Rx_OVERRUN} !== 2'b00) begin
            errors++;
            $display("FAIL reset_rx_flags: got %b expected 00",
                     {hif.Rx_PERROR, hif.Rx_OVERRUN});
        end
    endtask

    task automatic test_tx_frame();
        logic [31:0] got;
        logic [9:0]  exp;
        bit          ok;
        parity_mode = 2'b00;
        use_tx      = 1'b1;
        hif.Tx_EN   = 1'b1;
        exp = {1'b1, 8'hA5, 1'b0};
        write_word(8'hA5);
        capture_tx(10, got, ok);
        vectors++;
        if (!ok || got[9:0] !== exp) begin
            errors++;
            $display("FAIL tx_wave_A5: got %b ok=%0d expected %b",
                     got[9:0], ok, exp);
        end
        wait_valid(ok);
        vectors++;
        if (!ok || hif.Rx_DATA !== 8'hA5 || hif.Rx_FERROR !== 1'b0 ||
            hif.Rx_PERROR !== 1'b0) begin
            errors++;
            $display("FAIL rx_A5: valid=%0d data=%h fe=%b pe=%b expected 1 a5 0 0",
                     ok, hif.Rx_DATA, hif.Rx_FERROR, hif.Rx_PERROR);
        end
        rx_read();
        wait_tx_idle();
    endtask

    task automatic test_loopback();
        bit saw_low;
        bit ok;
        saw_low  = 1'b0;
        ok       = 1'b0;
        loopback = 1'b1;
        use_tx   = 1'b0;
        write_word(8'hA5);
        for (int i = 0; i < 600; i++) begin
            if (hif.Rx_VALID === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (tx_d !== 1'b1) saw_low = 1'b1;
            @(negedge clk);
        end
        vectors++;
        if (saw_low) begin
            errors++;
            $display("FAIL loopback_pin: got Tx_D low expected held 1");
        end
        vectors++;
        if (!ok || hif.Rx_DATA !== 8'hA5 || hif.Rx_FERROR !== 1'b0 ||
            hif.Rx_PERROR !== 1'b0) begin
            errors++;
            $display("FAIL loopback_rx: valid=%0d data=%h fe=%b pe=%b expected 1 a5 0 0",
                     ok, hif.Rx_DATA, hif.Rx_FERROR, hif.Rx_PERROR);
        end
        rx_read();
        wait_tx_idle();
        loopback = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] got;
        logic [21:0] exp;
        bit          ok;
        bit          ok1;
        bit          ok2;
        parity_mode = 2'b01;
        use_tx      = 1'b1;
        exp = {1'b1, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 8'h94, 1'b0};
        write_word(8'h94);
        write_word(8'hA1);
        fork
            capture_tx(22, got, ok);
            begin
                wait_valid(ok1);
                vectors++;
                if (!ok1 || hif.Rx_DATA !== 8'h94 ||
                    hif.Rx_PERROR !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_rx1: valid=%0d data=%h pe=%b expected 1 94 0",
                             ok1, hif.Rx_DATA, hif.Rx_PERROR);
                end
                rx_read();
                wait_valid(ok2);
                vectors++;
                if (!ok2 || hif.Rx_DATA !== 8'hA1 ||
                    hif.Rx_PERROR !== 1'b0 ||
                    hif.Rx_OVERRUN !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_rx2: valid=%0d data=%h pe=%b ov=%b expected 1 a1 0 0",
                             ok2, hif.Rx_DATA, hif.Rx_PERROR,
                             hif.Rx_OVERRUN);
                end
                rx_read();
            end
        join
        vectors++;
        if (!ok || got[21:0] !== exp) begin
            errors++;
            $display("FAIL b2b_wave: got %b ok=%0d expected %b",
                     got[21:0], ok, exp);
        end
        wait_tx_idle();
    endtask

    task automatic test_parity_error();
        bit ok;
        ok          = 1'b0;
        parity_mode = 2'b10;
        use_tx      = 1'b1;
        write_word(8'h94);
        for (int i = 0; i < 100; i++) begin
            if (tx_d === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        parity_mode = 2'b01;
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL perr_start: got no start bit expected one");
        end
        wait_valid(ok);
        vectors++;
        if (!ok || hif.Rx_DATA !== 8'h94 || hif.Rx_PERROR !== 1'b1 ||
            hif.Rx_FERROR !== 1'b0) begin
            errors++;
            $display("FAIL perr_flag: valid=%0d data=%h pe=%b fe=%b expected 1 94 1 0",
                     ok, hif.Rx_DATA, hif.Rx_PERROR, hif.Rx_FERROR);
        end
        rx_read();
        wait_tx_idle();
    endtask

    task automatic test_framing_error();
        bit ok;
        use_tx      = 1'b0;
        parity_mode = 2'b01;
        send_rx(8'h5A, 1'b1, 1'b0, 1'b0);
        wait_valid(ok);
        vectors++;
        if (!ok || hif.Rx_DATA !== 8'h5A || hif.Rx_FERROR !== 1'b1 ||
            hif.Rx_PERROR !== 1'b0) begin
            errors++;
            $display("FAIL ferr_flag: valid=%0d data=%h fe=%b pe=%b expected 1 5a 1 0",
                     ok, hif.Rx_DATA, hif.Rx_FERROR, hif.Rx_PERROR);
        end
        repeat (60) @(negedge clk);
        rx_read();
    endtask

    task automatic test_fifo_full();
        int cnt;
        bit ok;
        cnt         = 0;
        ok          = 1'b0;
        parity_mode = 2'b00;
        use_tx      = 1'b1;
        hif.Tx_EN   = 1'b0;
        write_word(8'h11);
        write_word(8'h22);
        write_word(8'h33);
        vectors++;
        if (hif.Tx_BUSY !== 1'b0) begin
            errors++;
            $display("FAIL fifo_busy3: got %b expected 0", hif.Tx_BUSY);
        end
        write_word(8'h44);
        vectors++;
        if (hif.Tx_BUSY !== 1'b1) begin
            errors++;
            $display("FAIL fifo_busy4: got %b expected 1", hif.Tx_BUSY);
        end
        write_word(8'h55);
        write_word(8'h66);
        vectors++;
        if ({hif.Tx_BUSY, hif.Tx_IDLE, tx_d} !== 3'b101) begin
            errors++;
            $display("FAIL fifo_hold: got busy/idle/txd %b expected 101",
                     {hif.Tx_BUSY, hif.Tx_IDLE, tx_d});
        end
        hif.Tx_EN = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (tx_d === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        while (ok && hif.Tx_IDLE !== 1'b1 && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        vectors++;
        if (!ok || cnt != 640) begin
            errors++;
            $display("FAIL fifo_drain_cycles: got %0d started=%0d expected 640",
                     cnt, ok);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (hif.Rx_DATA !== 8'h44 || hif.Rx_VALID !== 1'b1 ||
            hif.Rx_OVERRUN !== 1'b1) begin
            errors++;
            $display("FAIL fifo_last_word: data=%h v=%b ov=%b expected 44 1 1",
                     hif.Rx_DATA, hif.Rx_VALID, hif.Rx_OVERRUN);
        end
        rx_read();
    endtask

    task automatic test_overrun();
        use_tx      = 1'b0;
        parity_mode = 2'b00;
        send_rx(8'h3C, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (hif.Rx_VALID !== 1'b1 || hif.Rx_OVERRUN !== 1'b0 ||
            hif.Rx_DATA !== 8'h3C) begin
            errors++;
            $display("FAIL ovr_first: v=%b ov=%b data=%h expected 1 0 3c",
                     hif.Rx_VALID, hif.Rx_OVERRUN, hif.Rx_DATA);
        end
        send_rx(8'hC3, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (hif.Rx_VALID !== 1'b1 || hif.Rx_OVERRUN !== 1'b1 ||
            hif.Rx_DATA !== 8'hC3) begin
            errors++;
            $display("FAIL ovr_second: v=%b ov=%b data=%h expected 1 1 c3",
                     hif.Rx_VALID, hif.Rx_OVERRUN, hif.Rx_DATA);
        end
        rx_read();
        vectors++;
        if (hif.Rx_VALID !== 1'b0 || hif.Rx_OVERRUN !== 1'b0) begin
            errors++;
            $display("FAIL ovr_clear: v=%b ov=%b expected 0 0",
                     hif.Rx_VALID, hif.Rx_OVERRUN);
        end
    endtask

    task automatic test_glitch();
        rx_bb = 1'b0;
        repeat (4) @(negedge clk);
        rx_bb = 1'b1;
        repeat (60) @(negedge clk);
        vectors++;
        if (hif.Rx_VALID !== 1'b0 || hif.Rx_DATA !== 8'hC3) begin
            errors++;
            $display("FAIL glitch: v=%b data=%h expected 0 c3",
                     hif.Rx_VALID, hif.Rx_DATA);
        end
    endtask

    task automatic test_mid_frame_reset();
        bit ok;
        bit saw_low;
        ok          = 1'b0;
        saw_low     = 1'b0;
        use_tx      = 1'b0;
        parity_mode = 2'b00;
        send_rx(8'h5A, 1'b0, 1'b0, 1'b0);
        repeat (60) @(negedge clk);
        hif.Tx_EN = 1'b1;
        write_word(8'h00);
        write_word(8'h00);
        for (int i = 0; i < 50; i++) begin
            if (tx_d === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        repeat (40) @(negedge clk);
        vectors++;
        if (!ok || tx_d !== 1'b0 || hif.Rx_FERROR !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: started=%0d txd=%b fe=%b expected 1 0 1",
                     ok, tx_d, hif.Rx_FERROR);
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({tx_d, hif.Tx_IDLE, hif.Tx_BUSY} !== 3'b110) begin
            errors++;
            $display("FAIL mid_reset_tx: got txd/idle/busy %b expected 110",
                     {tx_d, hif.Tx_IDLE, hif.Tx_BUSY});
        end
        vectors++;
        if ({hif.Rx_VALID, hif.Rx_FERROR, hif.Rx_PERROR, hif.Rx_OVERRUN}
                !== 4'b0000 || hif.Rx_DATA !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset_rx: flags %b data %h expected 0000 00",
                     {hif.Rx_VALID, hif.Rx_FERROR, hif.Rx_PERROR,
                      hif.Rx_OVERRUN}, hif.Rx_DATA);
        end
        reset = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_d !== 1'b1) saw_low = 1'b1;
        end
        vectors++;
        if (saw_low || hif.Tx_IDLE !== 1'b1) begin
            errors++;
            $display("FAIL mid_flushed: low=%0d idle=%b expected 0 1",
                     saw_low, hif.Tx_IDLE);
        end
    endtask

    initial begin
        reset       = 1'b1;
        baud_select = 3'b111;
        parity_mode = 2'b00;
        loopback    = 1'b0;
        use_tx      = 1'b0;
        rx_bb       = 1'b1;
        hif.Tx_EN   = 1'b0;
        hif.Tx_WR   = 1'b0;
        hif.Tx_DATA = 8'h00;
        hif.Rx_EN   = 1'b1;
        hif.Rx_RD   = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_tx_frame();
        test_loopback();
        test_back_to_back();
        test_parity_error();
        test_framing_error();
        test_fifo_full();
        test_overrun();
        test_glitch();
        test_mid_frame_reset();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end
endmodule
